// File: rtl/arcabuco_muldiv_unit_pkg.sv
// Shared types and helpers for the arcabuco multiply/divide unit.
package arcabuco_core_pack;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } t_muldiv_opcode;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } t_muldiv_state;

  // Any divide-class op (quotient or remainder result)
  function automatic logic is_div_op(t_muldiv_opcode op);
    return (op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU});
  endfunction

  // Divide-class op whose result is the remainder
  function automatic logic is_rem_op(t_muldiv_opcode op);
    return (op inside {MD_REM, MD_REMU});
  endfunction

  // rs1 is interpreted as two's complement
  function automatic logic is_signed_rs1(t_muldiv_opcode op);
    return (op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
  endfunction

  // rs2 is interpreted as two's complement
  function automatic logic is_signed_rs2(t_muldiv_opcode op);
    return (op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM});
  endfunction

endpackage

// File: rtl/arcabuco_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with valid/ready handshakes,
// a destination tag, flush, and RISC-V defined corner-case results.
// Operands are converted to magnitudes on entry; one shared 2*XLEN+1 bit
// accumulator runs either shift-add (multiply) or restoring
// shift-subtract (divide); the sign is reapplied on the final step.
module arcabuco_muldiv_unit
  import arcabuco_core_pack::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  t_muldiv_opcode   in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  input  logic             flush
);

  localparam int CNT_W = $clog2(XLEN);
  localparam int ACC_W = 2 * XLEN + 1;

  t_muldiv_state      state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   acc_q;
  t_muldiv_opcode     op_q;
  logic [TAG_W-1:0]   tag_q;
  logic               rs1Neg_q;
  logic               rs2Neg_q;
  logic [XLEN-1:0]    mag2_q;
  logic [XLEN-1:0]    out_result_q;
  logic [TAG_W-1:0]   out_tag_q;

  logic               rs1Neg_d;
  logic               rs2Neg_d;
  logic [XLEN-1:0]    mag1_d;
  logic [XLEN-1:0]    mag2_d;
  logic               divByZero;
  logic               divOverflow;
  logic [XLEN-1:0]    special_d;

  logic [XLEN:0]      mulSum;
  logic [ACC_W-1:0]   divShift;
  logic [XLEN:0]      divTrial;
  logic [ACC_W-1:0]   acc_d;

  logic [2*XLEN-1:0]  product;
  logic [XLEN-1:0]    quotient;
  logic [XLEN-1:0]    remainder;
  logic [XLEN-1:0]    result_d;

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

  // Input side: operand signs, magnitudes and the corner cases that skip iteration
  always_comb begin
    rs1Neg_d    = is_signed_rs1(in_op) && in_rs1[XLEN-1];
    rs2Neg_d    = is_signed_rs2(in_op) && in_rs2[XLEN-1];
    mag1_d      = rs1Neg_d ? -in_rs1 : in_rs1;
    mag2_d      = rs2Neg_d ? -in_rs2 : in_rs2;
    divByZero   = is_div_op(in_op) && (in_rs2 == '0);
    divOverflow = is_div_op(in_op) && is_signed_rs1(in_op) &&
                  (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2 == '1);
    special_d   = '0;
    if (divByZero) begin
      special_d = is_rem_op(in_op) ? in_rs1 : '1;
    end else if (divOverflow) begin
      special_d = is_rem_op(in_op) ? '0 : in_rs1;
    end
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    mulSum   = acc_q[ACC_W-1:XLEN] + (acc_q[0] ? {1'b0, mag2_q} : '0);
    divShift = {acc_q[ACC_W-2:0], 1'b0};
    divTrial = divShift[ACC_W-1:XLEN] - {1'b0, mag2_q};
    if (is_div_op(op_q)) begin
      if (divShift[ACC_W-1:XLEN] >= {1'b0, mag2_q}) begin
        acc_d = {divTrial, divShift[XLEN-1:1], 1'b1};
      end else begin
        acc_d = divShift;
      end
    end else begin
      acc_d = {1'b0, mulSum, acc_q[XLEN-1:1]};
    end
  end

  // Sign restoration and result select from the final accumulator value
  always_comb begin
    product   = (rs1Neg_q ^ rs2Neg_q) ? -acc_d[2*XLEN-1:0] : acc_d[2*XLEN-1:0];
    quotient  = (rs1Neg_q ^ rs2Neg_q) ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
    remainder = rs1Neg_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
    case (op_q)
      MD_MUL:                      result_d = product[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_d = product[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             result_d = quotient;
      default:                     result_d = remainder;
    endcase
  end

  // Control FSM with registered result/tag; flush abandons any operation
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      op_q         <= MD_MUL;
      tag_q        <= '0;
      rs1Neg_q     <= 1'b0;
      rs2Neg_q     <= 1'b0;
      mag2_q       <= '0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q     <= in_op;
            tag_q    <= in_tag;
            rs1Neg_q <= rs1Neg_d;
            rs2Neg_q <= rs2Neg_d;
            mag2_q   <= mag2_d;
            acc_q    <= {{(XLEN+1){1'b0}}, mag1_d};
            cnt_q    <= CNT_W'(XLEN - 1);
            if (divByZero || divOverflow) begin
              state_q      <= DONE;
              out_result_q <= special_d;
              out_tag_q    <= in_tag;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= acc_d;
          if (cnt_q == '0) begin
            state_q      <= DONE;
            out_result_q <= result_d;
            out_tag_q    <= tag_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arcabuco_muldiv_unit.sv
// Self-checking bench for arcabuco_muldiv_unit (XLEN=32) against an
// arithmetic reference model built on native 64-bit integer operations.
module tb_arcabuco_muldiv_unit;
  import arcabuco_core_pack::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clock;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  t_muldiv_opcode   in_op;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             flush;

  int checks = 0;
  int errors = 0;

  arcabuco_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clock(clock), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .flush(flush)
  );

  // Free-running clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // RISC-V M-extension result computed with plain 64-bit arithmetic
  function automatic logic [31:0] refResult(t_muldiv_opcode op, logic [31:0] a, logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      MD_MUL:    begin p = sa * sb; return p[31:0]; end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub; return p[63:32]; end
      MD_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      MD_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return 32'(sa / sb);
      end
      MD_DIVU:   begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      MD_REM:    begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      default:   begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Cycles from accept edge to first sample showing out_valid
  function automatic int refLatency(t_muldiv_opcode op, logic [31:0] a, logic [31:0] b);
    logic divClass;
    logic signedDiv;
    divClass  = (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
    signedDiv = (op == MD_DIV) || (op == MD_REM);
    if (divClass && (b == 0)) return 1;
    if (signedDiv && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return XLEN + 1;
  endfunction

  // Single comparison point
  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  // Offer one operation and let it be accepted on the next rising edge
  task automatic applyStimulus(input t_muldiv_opcode op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] tag);
    @(negedge clock);
    checkOutput("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_rs1   = a;
    in_rs2   = b;
    in_tag   = tag;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  // Full transaction: latency, result, tag, optional backpressure, handshake
  task automatic runOp(input string name, input t_muldiv_opcode op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag, input int hold);
    int lat;
    logic stableOk;
    logic [31:0] expRes;
    expRes = refResult(op, a, b);
    applyStimulus(op, a, b, tag);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!out_valid && lat < 200);
    checkOutput({name, "_latency"}, 64'(lat), 64'(refLatency(op, a, b)));
    checkOutput({name, "_result"}, 64'(out_result), 64'(expRes));
    checkOutput({name, "_tag"}, 64'(out_tag), 64'(tag));
    checkOutput({name, "_in_ready_low"}, 64'(in_ready), 64'd0);
    if (hold > 0) begin
      stableOk = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(negedge clock);
        if (!(out_valid === 1'b1 && in_ready === 1'b0 && out_result === expRes && out_tag === tag))
          stableOk = 1'b0;
      end
      checkOutput({name, "_backpressure_stable"}, 64'(stableOk), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  // Watch for out_valid over a number of cycles (expected to stay low)
  task automatic watchQuiet(input string name, input int cycles);
    logic sawValid;
    sawValid = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clock);
      if (out_valid !== 1'b0) sawValid = 1'b1;
    end
    checkOutput(name, 64'(sawValid), 64'd0);
  endtask

  initial begin
    t_muldiv_opcode rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int sel;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = MD_MUL;
    in_rs1    = '0;
    in_rs2    = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    repeat (3) @(posedge clock);
    #1 rst = 1'b0;
    @(negedge clock);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_result", 64'(out_result), 64'd0);
    checkOutput("reset_out_tag", 64'(out_tag), 64'd0);

    // Directed arithmetic cases
    runOp("mul_7_m3", MD_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);
    runOp("mulhu_ff", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0);
    runOp("mulh_ff", MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
    runOp("mulhsu_m1_2", MD_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd3, 0);
    runOp("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);
    runOp("rem_m7_2", MD_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
    runOp("divu_100_7", MD_DIVU, 32'd100, 32'd7, 5'd7, 0);
    runOp("remu_100_7", MD_REMU, 32'd100, 32'd7, 5'd8, 0);
    runOp("div_5_0", MD_DIV, 32'd5, 32'd0, 5'd9, 0);
    runOp("rem_5_0", MD_REM, 32'd5, 32'd0, 5'd10, 0);
    runOp("divu_5_0", MD_DIVU, 32'd5, 32'd0, 5'd11, 0);
    runOp("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);
    runOp("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0);
    runOp("divu_minneg", MD_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0);

    // Backpressure, then an immediate follow-up accept
    runOp("bp_mulh", MD_MULH, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21, 5);
    runOp("bp_next", MD_REM, 32'h8765_4321, 32'd1000, 5'd22, 0);

    // Flush in the middle of an operation
    applyStimulus(MD_MUL, 32'd123, 32'd456, 5'd15);
    repeat (9) @(posedge clock);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    @(negedge clock);
    checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    watchQuiet("flush_no_result", 40);

    // Flush together with an offered op: nothing is accepted
    @(negedge clock);
    in_valid = 1'b1;
    in_op    = MD_DIVU;
    in_rs1   = 32'd99;
    in_rs2   = 32'd0;
    in_tag   = 5'd16;
    flush    = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clock);
    checkOutput("flush_accept_in_ready", 64'(in_ready), 64'd1);
    watchQuiet("flush_accept_no_result", 40);

    // Reset during CALC discards the operation
    applyStimulus(MD_DIV, 32'd1000, 32'd3, 5'd17);
    repeat (10) @(posedge clock);
    #1 rst = 1'b1;
    @(posedge clock);
    #1 rst = 1'b0;
    @(negedge clock);
    checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_out_result", 64'(out_result), 64'd0);
    checkOutput("midreset_out_tag", 64'(out_tag), 64'd0);
    watchQuiet("midreset_no_result", 40);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = t_muldiv_opcode'(3'($urandom_range(0, 7)));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      if (sel == 1) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      if (sel == 2) rb = 32'($urandom_range(1, 20));
      if (sel == 3) ra = -ra;
      runOp("random", rop, ra, rb, 5'($urandom), (i % 9 == 0) ? 2 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arcabuco_muldiv_unit.md
# arcabuco_muldiv_unit

Iterative, parametrised RV32M/RV64M multiply/divide unit for the arcabuco execution stage. It replaces the single-enable `muldiv_en` path with a valid/ready handshake, a result tag, a flush input and defined RISC-V corner-case results. It performs one radix-2 iteration per cycle and sits beside the ALU. Hazard logic stalls on `in_ready`/`out_valid`.

## Interface
- `XLEN`, 32: operand/result width; any even value ≥ 8.
- `TAG_W`, 5: width of the destination tag carried with the operation.
- `clock`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  unit can accept (IDLE only).
- `in_op`  in  t_muldiv_opcode  mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
- `in_rs1`, `in_rs2`  in  XLEN  operands.
- `in_tag`  in  TAG_W  destination tag.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `out_result`  out  XLEN  result.
- `out_tag`  out  TAG_W  tag of result.
- `flush`  in  1  abandon any in-flight operation.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: `in_ready`=1. On `in_valid`, latch op, tag, operand signs and absolute values, and load counter = XLEN-1.
  - Special case (div/rem with rs2=0, or signed overflow): go to DONE.
  - Otherwise: go to CALC.
- CALC: one shift-add (mul) or restoring shift-subtract (div) step per cycle.
  - After the step with counter=0: go to DONE.
  - Otherwise: decrement counter.
- DONE: `out_valid`=1, with `out_result`/`out_tag` stable. On `out_ready`: go to IDLE.
- Signedness:
  - mul/mulh: both signed.
  - mulhsu: rs1 signed, rs2 unsigned.
  - mulhu/divu/remu: unsigned.
  - div/rem: signed.
- Magnitudes are used internally. The product or quotient is negated when operand signs differ. The remainder takes the sign of the dividend.
- Result select:
  - mul: product[XLEN-1:0].
  - mulh*: product[2·XLEN-1:XLEN].
  - div*: quotient.
  - rem*: remainder.
- Divide by zero: quotient = all ones (div and divu); remainder = rs1.
- Overflow (div/rem, rs1 = most-negative, rs2 = −1): quotient = rs1; remainder = 0.
- `flush` in any state: go to IDLE next cycle. `out_valid` drops and no result is produced.
  - Flush beats an accept in the same cycle: the offered op is not taken.
  - Flush in DONE concurrent with `out_ready`: the result is consumed, then the unit goes to IDLE.
- `rst`: state=IDLE, counter=0, `out_valid`=0, `out_result`=0, `out_tag`=0, and `in_ready`=1 on the cycle after reset is released. Reset mid-operation discards the operation.

## Timing
- Accept at edge N (`in_valid` & `in_ready`).
  - Normal ops: `out_valid` high from cycle N+XLEN+1 (XLEN cycles in CALC).
  - Special cases: `out_valid` high from cycle N+1.
- `in_ready` and `out_valid` are never high together. There is no back-to-back accept; the next accept is possible one cycle after the result handshake.
- `out_result`/`out_tag` are registered and change only on entering DONE.
- `in_ready` = (state==IDLE). It does not depend on `in_valid` or `flush` combinationally.

## Structure
- `arcabuco_core_pack`:
  - existing `t_muldiv_opcode`.
  - new `t_muldiv_state` enum {IDLE, CALC, DONE}.
  - helper functions `is_div_op`, `is_signed_rs1`, `is_signed_rs2`.
- Single module with no sub-module. The datapath uses one 2·XLEN+1 accumulator shared by mul and div, a magnitude negator at input and output, and a $clog2(XLEN) counter.
- `arcabuco_execution` instantiates it in place of the existing muldiv path.

## Test plan
- XLEN=32, mul 7 × −3 (0xFFFFFFFD), tag 5 → `out_result`=0xFFFFFFEB, `out_tag`=5, `out_valid` at cycle N+33.
- mulhu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; mulh same operands → 0x00000000; mulhsu −1 × 2 → 0xFFFFFFFF.
- div −7/2 → 0xFFFFFFFD; rem −7/2 → 0xFFFFFFFF; divu 100/7 → 14; remu 100/7 → 2.
- Special cases:
  - div 5/0 → 0xFFFFFFFF and rem 5/0 → 5, both with `out_valid` at N+1.
  - div 0x80000000/0xFFFFFFFF → 0x80000000; rem same operands → 0.
- Flush and reset:
  - `flush` at cycle N+10 → `out_valid` stays 0 and `in_ready`=1 at N+11.
  - `flush` with `in_valid` in IDLE → no accept.
  - `rst` mid-CALC → all outputs at reset values.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → result/tag stable and `in_ready`=0. Then `out_ready`=1 → IDLE, and the next op is accepted the following cycle.
